// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef logic port_id_t;

    localparam port_id_t PORT_FETCH = 1'b0;
    localparam port_id_t PORT_DATA  = 1'b1;
    localparam int       NUM_PORTS  = 2;

endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of requester IDs; one entry per accepted-but-unanswered request.
import mem_arb_pkg::*;

module id_fifo #(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  port_id_t      push_id_i,
    input  logic          pop_i,
    output port_id_t      head_id_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    port_id_t      mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= PORT_FETCH;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) mem_q[wr_ptr_q] <= push_id_i;
        end
    end

    assign head_id_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one valid/ready memory port between fetch (p0) and load/store (p1).
// MEM_ARB_RR_EN selects round-robin on conflict; otherwise p1 has fixed priority.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic              p0_req_we,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_resp_valid,
    input  logic              p0_resp_ready,
    output logic [DATA_W-1:0] p0_resp_data,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic              p1_req_we,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_resp_valid,
    input  logic              p1_resp_ready,
    output logic [DATA_W-1:0] p1_resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    output logic              mem_resp_ready,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              err_spurious_resp
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_PORTS-1:0] req_v;
    port_id_t             grant, head_id;
    port_id_t             lock_id_q, lock_id_d, last_grant_q, last_grant_d;
    logic                 lock_q, lock_d, err_q, err_d;
    logic                 no_slot, req_fire, resp_pop;
    logic                 fifo_full, fifo_empty;
    logic [CW-1:0]        fifo_count;

    assign req_v = {p1_req_valid, p0_req_valid};

    always_comb begin
        grant = PORT_FETCH;
        if (lock_q) begin
            grant = lock_id_q;
        end else if (&req_v) begin
`ifdef MEM_ARB_RR_EN
            grant = ~last_grant_q;
`else
            grant = PORT_DATA;
`endif
        end else if (req_v[PORT_DATA]) begin
            grant = PORT_DATA;
        end
    end

    // A pop this cycle does not open a slot until the count register updates.
    assign no_slot       = (fifo_count == CW'(MAX_OUTSTANDING));
    assign mem_req_valid = req_v[grant] && !no_slot;
    assign mem_req_addr  = (grant == PORT_DATA) ? p1_req_addr  : p0_req_addr;
    assign mem_req_we    = (grant == PORT_DATA) ? p1_req_we    : p0_req_we;
    assign mem_req_wdata = (grant == PORT_DATA) ? p1_req_wdata : p0_req_wdata;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign p0_req_ready = req_fire && !fifo_full && (grant == PORT_FETCH);
    assign p1_req_ready = req_fire && !fifo_full && (grant == PORT_DATA);

    always_comb begin
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        last_grant_d = last_grant_q;
        if (req_fire) begin
            lock_d       = 1'b0;
            last_grant_d = grant;
        end else if (mem_req_valid) begin
            lock_d    = 1'b1;
            lock_id_d = grant;
        end
    end

    // With nothing outstanding, a response is swallowed and flagged.
    assign p0_resp_valid  = mem_resp_valid && !fifo_empty && (head_id == PORT_FETCH);
    assign p1_resp_valid  = mem_resp_valid && !fifo_empty && (head_id == PORT_DATA);
    assign p0_resp_data   = mem_resp_data;
    assign p1_resp_data   = mem_resp_data;
    assign mem_resp_ready = fifo_empty ? mem_resp_valid
                          : ((head_id == PORT_DATA) ? p1_resp_ready : p0_resp_ready);
    assign resp_pop       = mem_resp_valid && mem_resp_ready && !fifo_empty;
    assign err_d          = err_q || (mem_resp_valid && fifo_empty);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_id_q    <= PORT_FETCH;
            last_grant_q <= PORT_DATA;
            err_q        <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            last_grant_q <= last_grant_d;
            err_q        <= err_d;
        end
    end

    assign err_spurious_resp = err_q;

    id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (req_fire),
        .push_id_i (grant),
        .pop_i     (resp_pop),
        .head_id_o (head_id),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAX = 2;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0, reset = 1'b0;
    logic          p0_req_valid, p0_req_ready, p0_req_we, p0_resp_valid, p0_resp_ready;
    logic [AW-1:0] p0_req_addr;
    logic [DW-1:0] p0_req_wdata, p0_resp_data;
    logic          p1_req_valid, p1_req_ready, p1_req_we, p1_resp_valid, p1_resp_ready;
    logic [AW-1:0] p1_req_addr;
    logic [DW-1:0] p1_req_wdata, p1_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata, mem_resp_data;
    logic          mem_resp_valid, mem_resp_ready, err_spurious_resp;

    int errors = 0;
    int checks = 0;

    // Reference model state: issue-order queue of requester IDs plus arbitration memory.
    bit q_ids[$];
    bit lock_m, lock_id_m, last_m;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAX)) dut (
        .clk(clk), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
        .p0_req_we(p0_req_we), .p0_req_wdata(p0_req_wdata),
        .p0_resp_valid(p0_resp_valid), .p0_resp_ready(p0_resp_ready), .p0_resp_data(p0_resp_data),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
        .p1_req_we(p1_req_we), .p1_req_wdata(p1_req_wdata),
        .p1_resp_valid(p1_resp_valid), .p1_resp_ready(p1_resp_ready), .p1_resp_data(p1_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_data(mem_resp_data), .err_spurious_resp(err_spurious_resp)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        p0_req_valid = 0; p0_req_addr = '0; p0_req_we = 0; p0_req_wdata = '0; p0_resp_ready = 0;
        p1_req_valid = 0; p1_req_addr = '0; p1_req_we = 0; p1_req_wdata = '0; p1_resp_ready = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q_ids.delete();
        lock_m = 1'b0; lock_id_m = 1'b0; last_m = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        settle();
        checks++; if (err_spurious_resp !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_spurious_resp); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
        checks++; if ({p0_req_ready, p1_req_ready} !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", {p0_req_ready, p1_req_ready}); end
        checks++; if ({p0_resp_valid, p1_resp_valid} !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b want 00", {p0_resp_valid, p1_resp_valid}); end
        checks++; if (mem_resp_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_resp_ready: got %b want 0", mem_resp_ready); end
        tick();
        reset = 1'b0;
        tick();
        settle();
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b want 0", mem_req_valid); end
        tick();
    endtask

    task automatic test_single_read;
        do_reset();
        p0_req_valid = 1; p0_req_addr = 32'h100; mem_req_ready = 1;
        settle();
        checks++; if (p0_req_ready !== 1'b1) begin errors++; $display("FAIL single_p0_ready: got %b want 1", p0_req_ready); end
        checks++; if (p1_req_ready !== 1'b0) begin errors++; $display("FAIL single_p1_ready: got %b want 0", p1_req_ready); end
        checks++; if (mem_req_addr !== 32'h100 || mem_req_we !== 1'b0) begin errors++; $display("FAIL single_addr: got %h/%b want 100/0", mem_req_addr, mem_req_we); end
        tick();
        p0_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'hDEADBEEF; p0_resp_ready = 1;
        settle();
        checks++; if (p0_resp_valid !== 1'b1 || p0_resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_resp: got %b/%h want 1/deadbeef", p0_resp_valid, p0_resp_data); end
        checks++; if (p1_resp_valid !== 1'b0) begin errors++; $display("FAIL single_p1_resp: got %b want 0", p1_resp_valid); end
        checks++; if (mem_resp_ready !== 1'b1) begin errors++; $display("FAIL single_mem_resp_ready: got %b want 1", mem_resp_ready); end
        tick();
        idle_inputs();
        settle();
        checks++; if (err_spurious_resp !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err_spurious_resp); end
        tick();
    endtask

    task automatic test_arbitration;
        do_reset();
        p0_req_valid = 1; p0_req_addr = 32'hA0; p1_req_valid = 1; p1_req_addr = 32'hB0;
        mem_req_ready = 1; p0_resp_ready = 1; p1_resp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            bit g;
            g = RR ? bit'(i % 2) : 1'b1;
            settle();
            checks++; if ({p1_req_ready, p0_req_ready} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL arb_cycle%0d: got p1,p0=%b want grant %0d", i, {p1_req_ready, p0_req_ready}, g); end
            checks++; if (mem_req_addr !== (g ? 32'hB0 : 32'hA0)) begin errors++; $display("FAIL arb_addr%0d: got %h want %h", i, mem_req_addr, g ? 32'hB0 : 32'hA0); end
            tick();
            mem_resp_valid = 1;
        end
        p0_req_valid = 0; p1_req_valid = 0;
        tick();
        idle_inputs();
        settle();
        checks++; if (err_spurious_resp !== 1'b0) begin errors++; $display("FAIL arb_err: got %b want 0", err_spurious_resp); end
        tick();
    endtask

    task automatic test_lock;
        do_reset();
        p0_req_valid = 1; p0_req_addr = 32'hC0; p1_req_addr = 32'hD0; mem_req_ready = 0;
        settle();
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'hC0 || p0_req_ready !== 1'b0) begin errors++; $display("FAIL lock_start: got v=%b a=%h r=%b want 1/c0/0", mem_req_valid, mem_req_addr, p0_req_ready); end
        tick();
        p1_req_valid = 1;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if (mem_req_addr !== 32'hC0 || p1_req_ready !== 1'b0) begin errors++; $display("FAIL lock_hold%0d: got a=%h p1r=%b want c0/0", i, mem_req_addr, p1_req_ready); end
            tick();
        end
        mem_req_ready = 1;
        settle();
        checks++; if ({p1_req_ready, p0_req_ready} !== 2'b01) begin errors++; $display("FAIL lock_fire: got p1,p0=%b want 01", {p1_req_ready, p0_req_ready}); end
        tick();
        p0_req_valid = 0;
        settle();
        checks++; if (p1_req_ready !== 1'b1 || mem_req_addr !== 32'hD0) begin errors++; $display("FAIL lock_next: got r=%b a=%h want 1/d0", p1_req_ready, mem_req_addr); end
        tick();
        idle_inputs();
        mem_resp_valid = 1; p0_resp_ready = 1; p1_resp_ready = 1;
        settle();
        checks++; if ({p1_resp_valid, p0_resp_valid} !== 2'b01) begin errors++; $display("FAIL lock_resp0: got %b want 01", {p1_resp_valid, p0_resp_valid}); end
        tick();
        settle();
        checks++; if ({p1_resp_valid, p0_resp_valid} !== 2'b10) begin errors++; $display("FAIL lock_resp1: got %b want 10", {p1_resp_valid, p0_resp_valid}); end
        tick();
        idle_inputs();
    endtask

    task automatic test_full;
        do_reset();
        mem_req_ready = 1; p0_req_valid = 1; p0_req_addr = 32'h10;
        tick();
        p0_req_addr = 32'h14;
        tick();
        p0_req_valid = 0; p1_req_valid = 1; p1_req_addr = 32'h20;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if (p1_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin errors++; $display("FAIL full_block%0d: got r=%b v=%b want 0/0", i, p1_req_ready, mem_req_valid); end
            tick();
        end
        mem_resp_valid = 1; p0_resp_ready = 1;
        settle();
        checks++; if (p1_req_ready !== 1'b0 || p0_resp_valid !== 1'b1) begin errors++; $display("FAIL full_popcycle: got r=%b rv=%b want 0/1", p1_req_ready, p0_resp_valid); end
        tick();
        mem_resp_valid = 0;
        settle();
        checks++; if (p1_req_ready !== 1'b1) begin errors++; $display("FAIL full_accept: got %b want 1", p1_req_ready); end
        tick();
        p1_req_valid = 0; mem_resp_valid = 1; p1_resp_ready = 1;
        settle();
        checks++; if (p0_resp_valid !== 1'b1) begin errors++; $display("FAIL full_drain0: got %b want 1", p0_resp_valid); end
        tick();
        settle();
        checks++; if (p1_resp_valid !== 1'b1) begin errors++; $display("FAIL full_drain1: got %b want 1", p1_resp_valid); end
        tick();
        idle_inputs();
    endtask

    task automatic test_order;
        do_reset();
        mem_req_ready = 1; p1_req_valid = 1; p1_req_we = 1; p1_req_addr = 32'h40; p1_req_wdata = 32'hAA55;
        settle();
        checks++; if (mem_req_we !== 1'b1 || mem_req_wdata !== 32'hAA55 || p1_req_ready !== 1'b1) begin errors++; $display("FAIL order_write: got we=%b wd=%h r=%b want 1/aa55/1", mem_req_we, mem_req_wdata, p1_req_ready); end
        tick();
        p1_req_valid = 0; p0_req_valid = 1; p0_req_addr = 32'h44;
        settle();
        checks++; if (p0_req_ready !== 1'b1 || mem_req_we !== 1'b0) begin errors++; $display("FAIL order_read: got r=%b we=%b want 1/0", p0_req_ready, mem_req_we); end
        tick();
        p0_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 32'h0; p0_resp_ready = 1; p1_resp_ready = 1;
        settle();
        checks++; if ({p1_resp_valid, p0_resp_valid} !== 2'b10) begin errors++; $display("FAIL order_first: got p1,p0=%b want 10", {p1_resp_valid, p0_resp_valid}); end
        tick();
        mem_resp_data = 32'h1234;
        settle();
        checks++; if ({p1_resp_valid, p0_resp_valid} !== 2'b01 || p0_resp_data !== 32'h1234) begin errors++; $display("FAIL order_second: got %b/%h want 01/1234", {p1_resp_valid, p0_resp_valid}, p0_resp_data); end
        tick();
        idle_inputs();
    endtask

    task automatic test_spurious;
        do_reset();
        mem_resp_valid = 1; p0_resp_ready = 0; p1_resp_ready = 0;
        settle();
        checks++; if ({p1_resp_valid, p0_resp_valid} !== 2'b00 || mem_resp_ready !== 1'b1) begin errors++; $display("FAIL spur_route: got rv=%b mrr=%b want 00/1", {p1_resp_valid, p0_resp_valid}, mem_resp_ready); end
        checks++; if (err_spurious_resp !== 1'b0) begin errors++; $display("FAIL spur_same_cycle: got %b want 0", err_spurious_resp); end
        tick();
        mem_resp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (err_spurious_resp !== 1'b1) begin errors++; $display("FAIL spur_sticky%0d: got %b want 1", i, err_spurious_resp); end
            tick();
        end
        reset = 1'b1;
        #1;
        checks++; if (err_spurious_resp !== 1'b0) begin errors++; $display("FAIL spur_reset_clear: got %b want 0", err_spurious_resp); end
        tick();
        reset = 1'b0;
        // A request in flight when reset hits is forgotten; its response is spurious.
        mem_req_ready = 1; p0_req_valid = 1; p0_req_addr = 32'h80;
        tick();
        p0_req_valid = 0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        mem_resp_valid = 1; p0_resp_ready = 1;
        settle();
        checks++; if (p0_resp_valid !== 1'b0 || mem_resp_ready !== 1'b1) begin errors++; $display("FAIL midreset_route: got rv=%b mrr=%b want 0/1", p0_resp_valid, mem_resp_ready); end
        tick();
        mem_resp_valid = 0;
        settle();
        checks++; if (err_spurious_resp !== 1'b1) begin errors++; $display("FAIL midreset_err: got %b want 1", err_spurious_resp); end
        tick();
        idle_inputs();
    endtask

    task automatic test_random;
        bit hold0, hold1;
        int bad;
        do_reset();
        hold0 = 0; hold1 = 0; bad = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit full, g, emv, er0, er1, erv0, erv1, emrr;
            if (!hold0) begin
                p0_req_valid = ($urandom_range(0, 2) != 0); p0_req_addr = $urandom;
                p0_req_we = $urandom_range(0, 1); p0_req_wdata = $urandom;
            end
            if (!hold1) begin
                p1_req_valid = ($urandom_range(0, 2) != 0); p1_req_addr = $urandom;
                p1_req_we = $urandom_range(0, 1); p1_req_wdata = $urandom;
            end
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            mem_resp_valid = (q_ids.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_resp_data  = $urandom;
            p0_resp_ready  = $urandom_range(0, 1);
            p1_resp_ready  = $urandom_range(0, 1);
            settle();

            full = (q_ids.size() == MAX);
            if (lock_m) g = lock_id_m;
            else if (p0_req_valid && p1_req_valid) g = RR ? !last_m : 1'b1;
            else g = p1_req_valid;
            emv = !full && (g ? p1_req_valid : p0_req_valid);
            er0 = emv && mem_req_ready && !g;
            er1 = emv && mem_req_ready && g;
            if (q_ids.size() > 0) begin
                erv0 = mem_resp_valid && !q_ids[0];
                erv1 = mem_resp_valid && q_ids[0];
                emrr = q_ids[0] ? p1_resp_ready : p0_resp_ready;
            end else begin
                erv0 = 0; erv1 = 0; emrr = mem_resp_valid;
            end

            checks++;
            if (mem_req_valid !== emv || p0_req_ready !== er0 || p1_req_ready !== er1 ||
                p0_resp_valid !== erv0 || p1_resp_valid !== erv1 || mem_resp_ready !== emrr ||
                (emv && mem_req_addr !== (g ? p1_req_addr : p0_req_addr)) ||
                ((erv0 || erv1) && p0_resp_data !== mem_resp_data)) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_cyc%0d: got mv=%b r=%b%b rv=%b%b mrr=%b want mv=%b r=%b%b rv=%b%b mrr=%b",
                             cyc, mem_req_valid, p1_req_ready, p0_req_ready, p1_resp_valid, p0_resp_valid,
                             mem_resp_ready, emv, er1, er0, erv1, erv0, emrr);
                bad++;
            end

            if (q_ids.size() > 0 && mem_resp_valid && emrr) void'(q_ids.pop_front());
            if (emv && mem_req_ready) begin
                q_ids.push_back(g); last_m = g; lock_m = 0;
            end else if (emv) begin
                lock_m = 1; lock_id_m = g;
            end
            hold0 = p0_req_valid && !er0;
            hold1 = p1_req_valid && !er1;
            tick();
        end
        idle_inputs();
        settle();
        checks++; if (err_spurious_resp !== 1'b0) begin errors++; $display("FAIL random_err: got %b want 0", err_spurious_resp); end
        tick();
    endtask

    initial begin
        idle_inputs();
        lock_m = 0; lock_id_m = 0; last_m = 1;
        test_reset();
        test_single_read();
        test_arbitration();
        test_lock();
        test_full();
        test_order();
        test_spurious();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one valid/ready memory port between the fetch stage (port 0) and the load/store unit (port 1). It grants one request per cycle onto the shared port and records the winner's ID in an in-order ID FIFO. It then routes each returning response to the port that issued it. It sits between the CPU core and the single-ported memory model/bus.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MAX_OUTSTANDING`, default 2: ID FIFO depth, i.e. the number of accepted-but-unanswered requests (1..8).
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  reset, asynchronous and active-high. One clock; reset is asynchronous and active-high.
- `pN_req_valid`  in  1  request from port N (N = 0 fetch, 1 data).
- `pN_req_ready`  out  1  request accepted this cycle when high with `pN_req_valid`.
- `pN_req_addr`  in  ADDR_W  request address.
- `pN_req_we`  in  1  write request when high.
- `pN_req_wdata`  in  DATA_W  write data.
- `pN_resp_valid`  out  1  response for port N.
- `pN_resp_ready`  in  1  port N accepts its response.
- `pN_resp_data`  out  DATA_W  read data (don't-care for writes).
- `mem_req_valid` / `mem_req_ready`  out / in  1  shared request handshake.
- `mem_req_addr`, `mem_req_we`, `mem_req_wdata`  out  ADDR_W/1/DATA_W  muxed from the granted port.
- `mem_resp_valid` / `mem_resp_ready`  in / out  1  shared response handshake.
- `mem_resp_data`  in  DATA_W  response data.
- `err_spurious_resp`  out  1  sticky flag: a response arrived with no outstanding request.

## Operation
- Every accepted request, read or write, produces exactly one response. Responses return in issue order.
- Grant is computed combinationally from the request valids, `lock`, the arbitration state and the FIFO count. The request path has zero latency: `mem_req_*` equals the granted port's fields.
- No grant while `count == MAX_OUTSTANDING`: `mem_req_valid` = 0 and both `pN_req_ready` = 0. A response pop in the same cycle does not free a slot until the next cycle.
- `pN_req_ready = granted(N) && mem_req_ready && !full`. Non-granted ports see ready = 0.
- Lock: if `mem_req_valid && !mem_req_ready`, register `lock` = 1 and `lock_id` = granted port. While locked, the grant is forced to `lock_id`. `lock` clears on the fire. Requesters must hold valid and fields stable until ready.
- On request fire (`mem_req_valid && mem_req_ready`): push the granted ID into the FIFO and increment `count`.
- Response routing: the FIFO head ID selects the port.
  - `p<head>_resp_valid = mem_resp_valid && !empty`; the other port's `resp_valid` = 0.
  - `pN_resp_data = mem_resp_data`.
  - `mem_resp_ready = p<head>_resp_ready`.
  - On response fire: pop and decrement `count`.
- Push and pop in the same cycle leave `count` unchanged.
- Empty FIFO and `mem_resp_valid` = 1:
  - `mem_resp_ready` = 1 (the response is discarded).
  - No port sees `resp_valid`.
  - `err_spurious_resp` is set the next cycle and cleared only by `reset`.
- FIFO pointers wrap modulo `MAX_OUTSTANDING`. `count` is `$clog2(MAX_OUTSTANDING+1)` bits wide.

## Timing
- Reset values:
  - `count` = 0, `lock` = 0, `last_grant` = 1, `err_spurious_resp` = 0.
  - All `pN_req_ready`, `pN_resp_valid`, `mem_req_valid` = 0. `mem_resp_ready` = 0 unless `mem_resp_valid` (spurious path).
- Request latency is 0 cycles (combinational pass-through). Response latency is 0 cycles (combinational routing).
- Sustained throughput is one request per cycle while not full.
- `reset` mid-transaction: outstanding IDs are dropped. Responses that arrive afterwards are treated as spurious and set `err_spurious_resp`.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On conflict, grant the port ≠ `last_grant`.
  - `last_grant` updates on each request fire.
  - After reset, port 0 wins the first conflict.
- `MEM_ARB_RR_EN` undefined: fixed priority, port 1 (data) always beats port 0 (fetch).
  - `last_grant` is still maintained but does not affect the grant.
- Lock behaviour is identical in both builds.

## Structure
- Package `mem_arb_pkg`:
  - typedef `port_id_t` (1 bit).
  - constants `PORT_FETCH` = 0, `PORT_DATA` = 1, `NUM_PORTS` = 2.
- Sub-module `id_fifo`: synchronous FIFO of `port_id_t` with push/pop, `count`, full/empty, and async active-high reset. The top holds the grant logic, lock, `last_grant`, muxes and error flag.

## Test plan
- Only p0 reads 0x100, memory ready, response 0xDEADBEEF one cycle later → p0 sees `req_ready` in the same cycle and `resp_valid` with 0xDEADBEEF; p1 sees no `resp_valid`.
- Both ports valid every cycle, `MEM_ARB_RR_EN` defined → grants alternate 0,1,0,1. Undefined → p1 is granted every cycle and p0 starves.
- p0 wins the grant, `mem_req_ready` low for 3 cycles while p1 raises valid → grant stays on p0 until its fire, then p1 is granted.
- `MAX_OUTSTANDING` = 2, two requests accepted with no responses → third request sees ready = 0 until the first response fire, and is accepted one cycle later.
- Issue p1 write then p0 read, responses return in order → first response goes to p1, second (0x1234) to p0.
- `mem_resp_valid` pulse with `count` = 0 → no port `resp_valid`, `mem_resp_ready` = 1, `err_spurious_resp` high from the next cycle until `reset`.
